// File: rtl/int_controller_pkg.sv
// Shared types and constants for the interrupt controller.
// Optional feature macro: INT_NESTING_EN (enables preemption by higher-priority sources).
package int_controller_pkg;

  localparam int unsigned AW   = 10;
  localparam int unsigned NIRQ = 4;

  localparam logic [AW-1:0] VEC0_DEF = 10'b1111111011;
  localparam logic [AW-1:0] VEC1_DEF = 10'b1111111110;
  localparam logic [AW-1:0] VEC2_DEF = 10'b1111111101;
  localparam logic [AW-1:0] VEC3_DEF = 10'b1111111100;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPush    = 3'd1,
    StVector  = 3'd2,
    StService = 3'd3,
    StReturn  = 3'd4
  } state_e;

  // One-hot mask for a source index.
  function automatic logic [NIRQ-1:0] onehot(input logic [1:0] id);
    logic [NIRQ-1:0] m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/int_controller_prio_enc4.sv
// 4-input priority encoder; lowest set index wins.
// Used for grant selection and, with INT_NESTING_EN, for in-service priority.
module int_controller_prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  // Scan from the highest-priority (lowest) index.
  always_comb begin
    id    = 2'd0;
    valid = 1'b1;
    if (req[0])      id = 2'd0;
    else if (req[1]) id = 2'd1;
    else if (req[2]) id = 2'd2;
    else if (req[3]) id = 2'd3;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge-latched requests, mask, priority grant at instruction
// boundaries, and push/vector/pop sequencing towards the return stack and PC mux.
// Optional feature macro: INT_NESTING_EN (higher-priority sources preempt a running service).
module int_controller
  import int_controller_pkg::*;
#(
  parameter logic [AW-1:0] VEC0 = VEC0_DEF,
  parameter logic [AW-1:0] VEC1 = VEC1_DEF,
  parameter logic [AW-1:0] VEC2 = VEC2_DEF,
  parameter logic [AW-1:0] VEC3 = VEC3_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            gie,
  input  logic            instr_done,
  input  logic            reti,
  input  logic [AW-1:0]   pc_in,
  output logic            push,
  output logic [AW-1:0]   push_data,
  output logic            pop,
  output logic            load_pc,
  output logic [AW-1:0]   vec_out,
  output logic [NIRQ-1:0] in_service,
  output logic            busy
);

  state_e          state;
  logic [1:0]      id_q;
  logic [NIRQ-1:0] irq_d;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;

  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr;
  logic [1:0]      win_id;
  logic            win_valid;
  logic [1:0]      svc_id;
  logic            svc_valid;
  logic [NIRQ-1:0] ret_mask;
  logic            grant_ok;
  logic [AW-1:0]   vec_sel;

  int_controller_prio_enc4 u_grant_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  int_controller_prio_enc4 u_svc_enc (
    .req   (in_service),
    .id    (svc_id),
    .valid (svc_valid)
  );

  // Grant qualification, vector lookup and pending-clear for the captured winner.
  always_comb begin
    eligible = pending & mask;
    grant_ok = gie & instr_done & win_valid;
    clr      = (state == StPush) ? onehot(id_q) : '0;
    ret_mask = svc_valid ? onehot(svc_id) : '0;
    unique case (id_q)
      2'd0:    vec_sel = VEC0;
      2'd1:    vec_sel = VEC1;
      2'd2:    vec_sel = VEC2;
      default: vec_sel = VEC3;
    endcase
  end

  assign busy = (state != StIdle);

  // Edge capture into pending; the grant clear wins over a same-cycle edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_d   <= irq;
      pending <= (pending | (irq & ~irq_d)) & ~clr;
      if (mask_we) mask <= mask_in;
    end
  end

  // Sequencer with registered one-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      id_q       <= 2'd0;
      push       <= 1'b0;
      push_data  <= '0;
      pop        <= 1'b0;
      load_pc    <= 1'b0;
      vec_out    <= '0;
      in_service <= '0;
    end else begin
      push    <= 1'b0;
      pop     <= 1'b0;
      load_pc <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_ok) begin
            state     <= StPush;
            id_q      <= win_id;
            push      <= 1'b1;
            push_data <= pc_in;
          end
        end
        StPush: begin
          state            <= StVector;
          load_pc          <= 1'b1;
          vec_out          <= vec_sel;
          in_service[id_q] <= 1'b1;
        end
        StVector: state <= StService;
        StService: begin
          if (reti) begin
            state      <= StReturn;
            pop        <= 1'b1;
            in_service <= in_service & ~ret_mask;
          end
`ifdef INT_NESTING_EN
          // Preempt only with a source strictly above every active service.
          else if (grant_ok && (win_id < svc_id)) begin
            state     <= StPush;
            id_q      <= win_id;
            push      <= 1'b1;
            push_data <= pc_in;
          end
`endif
        end
        StReturn: state <= (|in_service) ? StService : StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (both INT_NESTING_EN builds).
module tb_int_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       gie;
  logic       instr_done;
  logic       reti;
  logic [9:0] pc_in;
  logic       push;
  logic [9:0] push_data;
  logic       pop;
  logic       load_pc;
  logic [9:0] vec_out;
  logic [3:0] in_service;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .gie        (gie),
    .instr_done (instr_done),
    .reti       (reti),
    .pc_in      (pc_in),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .load_pc    (load_pc),
    .vec_out    (vec_out),
    .in_service (in_service),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave service with one reti, then settle back to IDLE.
  task automatic leave_service();
    reti = 1'b1;
    step();
    reti = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = '0; mask_we = 0; mask_in = '0; gie = 0;
    instr_done = 0; reti = 0; pc_in = '0;
    step(); step();
    n_cmp++;
    if ({push, pop, load_pc, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_strobes got %b want 0000", {push, pop, load_pc, busy});
    end
    n_cmp++;
    if ({push_data, vec_out, in_service} !== 24'h0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", {push_data, vec_out, in_service});
    end
    reset = 1'b1;
    step();
    mask_we = 1; mask_in = 4'b1111; gie = 1;
    step();
    mask_we = 0;
  endtask

  task automatic test_single();
    irq = 4'b0100;
    step();
    irq = '0; instr_done = 1; pc_in = 10'h055;
    step();
    instr_done = 0;
    n_cmp++;
    if ({push, load_pc, push_data} !== {2'b10, 10'h055}) begin
      n_bad++; $display("FAIL single_push got %b/%b/%h want 1/0/055", push, load_pc, push_data);
    end
    step();
    n_cmp++;
    if ({push, load_pc, vec_out, in_service} !== {2'b01, 10'b1111111101, 4'b0100}) begin
      n_bad++; $display("FAIL single_vec got %b/%b/%b/%b want 0/1/1111111101/0100",
                        push, load_pc, vec_out, in_service);
    end
    step();
    n_cmp++;
    if ({busy, load_pc, pop} !== 3'b100) begin
      n_bad++; $display("FAIL single_service got %b want 100", {busy, load_pc, pop});
    end
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if ({pop, in_service} !== 5'b1_0000) begin
      n_bad++; $display("FAIL single_pop got %b/%b want 1/0000", pop, in_service);
    end
    step();
    n_cmp++;
    if ({pop, busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_idle got %b want 00", {pop, busy});
    end
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    step();
    irq = '0; instr_done = 1; pc_in = 10'h100;
    step();
    n_cmp++;
    if (push !== 1'b1) begin
      n_bad++; $display("FAIL prio_push1 got %b want 1", push);
    end
    step();
    n_cmp++;
    if ({load_pc, vec_out, in_service} !== {1'b1, 10'b1111111110, 4'b0010}) begin
      n_bad++; $display("FAIL prio_vec1 got %b/%b/%b want 1/1111111110/0010",
                        load_pc, vec_out, in_service);
    end
    step();
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if (pop !== 1'b1) begin
      n_bad++; $display("FAIL prio_pop got %b want 1", pop);
    end
    step();
    step();
    n_cmp++;
    if (push !== 1'b1) begin
      n_bad++; $display("FAIL prio_push3 got %b want 1", push);
    end
    step();
    instr_done = 0;
    n_cmp++;
    if ({load_pc, vec_out, in_service} !== {1'b1, 10'b1111111100, 4'b1000}) begin
      n_bad++; $display("FAIL prio_vec3 got %b/%b/%b want 1/1111111100/1000",
                        load_pc, vec_out, in_service);
    end
    step();
    leave_service();
  endtask

  task automatic test_mask();
    int seen = 0;
    mask_we = 1; mask_in = 4'b1110;
    step();
    mask_we = 0; irq = 4'b0001;
    step();
    irq = '0; instr_done = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (push || load_pc) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL mask_block got %0d strobes want 0", seen);
    end
    mask_we = 1; mask_in = 4'b1111;
    step();
    mask_we = 0;
    step();
    n_cmp++;
    if (push !== 1'b1) begin
      n_bad++; $display("FAIL mask_push got %b want 1", push);
    end
    step();
    instr_done = 0;
    n_cmp++;
    if ({load_pc, vec_out} !== {1'b1, 10'b1111111011}) begin
      n_bad++; $display("FAIL mask_vec got %b/%b want 1/1111111011", load_pc, vec_out);
    end
    step();
    leave_service();
  endtask

  task automatic test_reti_idle_and_held();
    int pushes = 0;
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if ({pop, busy} !== 2'b00) begin
      n_bad++; $display("FAIL reti_idle got %b want 00", {pop, busy});
    end
    instr_done = 1; irq = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      if (push) pushes++;
    end
    irq = '0; reti = 1;
    step();
    reti = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (push) pushes++;
    end
    instr_done = 0;
    n_cmp++;
    if (pushes !== 1) begin
      n_bad++; $display("FAIL held_irq got %0d grants want 1", pushes);
    end
    n_cmp++;
    if ({busy, in_service} !== 5'b0_0000) begin
      n_bad++; $display("FAIL held_idle got %b want 00000", {busy, in_service});
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    irq = 4'b0100;
    step();
    irq = '0; instr_done = 1;
    step();
    n_cmp++;
    if (push !== 1'b1) begin
      n_bad++; $display("FAIL abort_push got %b want 1", push);
    end
    reset = 0;
    #1;
    n_cmp++;
    if ({push, pop, load_pc, busy, push_data, vec_out, in_service} !== 28'h0) begin
      n_bad++; $display("FAIL abort_clear got %h want 0",
                        {push, pop, load_pc, busy, push_data, vec_out, in_service});
    end
    step();
    reset = 1;
    step();
    mask_we = 1; mask_in = 4'b1111;
    step();
    mask_we = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (push || load_pc || busy) seen++;
    end
    instr_done = 0;
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL abort_after got %0d strobes want 0", seen);
    end
  endtask

  task automatic test_nesting();
    irq = 4'b1000; instr_done = 1; pc_in = 10'h010;
    step();
    irq = '0;
    step();
    step();
    n_cmp++;
    if ({load_pc, vec_out, in_service} !== {1'b1, 10'b1111111100, 4'b1000}) begin
      n_bad++; $display("FAIL nest_first got %b/%b/%b want 1/1111111100/1000",
                        load_pc, vec_out, in_service);
    end
    step();
    irq = 4'b0001; pc_in = 10'h020;
    step();
    irq = '0;
    step();
`ifdef INT_NESTING_EN
    n_cmp++;
    if ({push, push_data} !== {1'b1, 10'h020}) begin
      n_bad++; $display("FAIL nest_push got %b/%h want 1/020", push, push_data);
    end
    step();
    n_cmp++;
    if ({load_pc, vec_out, in_service} !== {1'b1, 10'b1111111011, 4'b1001}) begin
      n_bad++; $display("FAIL nest_vec got %b/%b/%b want 1/1111111011/1001",
                        load_pc, vec_out, in_service);
    end
    step();
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if ({pop, in_service} !== 5'b1_1000) begin
      n_bad++; $display("FAIL nest_pop1 got %b/%b want 1/1000", pop, in_service);
    end
    step();
    n_cmp++;
    if ({pop, busy, push} !== 3'b010) begin
      n_bad++; $display("FAIL nest_resume got %b want 010", {pop, busy, push});
    end
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if ({pop, in_service} !== 5'b1_0000) begin
      n_bad++; $display("FAIL nest_pop2 got %b/%b want 1/0000", pop, in_service);
    end
    step();
    instr_done = 0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL nest_idle got %b want 0", busy);
    end
`else
    step();
    n_cmp++;
    if ({push, load_pc, in_service} !== {2'b00, 4'b1000}) begin
      n_bad++; $display("FAIL nonest_wait got %b/%b/%b want 0/0/1000",
                        push, load_pc, in_service);
    end
    reti = 1;
    step();
    reti = 0;
    n_cmp++;
    if ({pop, in_service} !== 5'b1_0000) begin
      n_bad++; $display("FAIL nonest_pop got %b/%b want 1/0000", pop, in_service);
    end
    step();
    step();
    n_cmp++;
    if ({push, push_data} !== {1'b1, 10'h020}) begin
      n_bad++; $display("FAIL nonest_push got %b/%h want 1/020", push, push_data);
    end
    step();
    instr_done = 0;
    n_cmp++;
    if ({load_pc, vec_out, in_service} !== {1'b1, 10'b1111111011, 4'b0001}) begin
      n_bad++; $display("FAIL nonest_vec got %b/%b/%b want 1/1111111011/0001",
                        load_pc, vec_out, in_service);
    end
    step();
    leave_service();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_reti_idle_and_held();
    test_reset_abort();
    test_nesting();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
